alu_issue_ctrl: RTL and testbench
=================================

Name: alu_issue_ctrl

Overview:
- Request/response front end for the 4-bit bit-serial ALU stage.
- Accepts operations over a valid/ready request port and buffers them in a small FIFO.
- Holds A, B and opCode stable at the ALU for exactly one full 5-phase serial pass, then captures C/Carry/Sign/Zero into a response register with a valid/ready handshake.
- Sits directly upstream of the ALU and owns its opCode sequencing.

Parameters:
- WIDTH, 4, operand/result width.
- OP_W, 3, opcode width.
- SERIAL_CYCLES, 5, cycles a legal op is held at the ALU (phases S0..S4).
- FIFO_DEPTH, 2, request FIFO entries (power of two).

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  1  request present
- req_ready  out  1  FIFO can accept
- req_a  in  WIDTH  operand A
- req_b  in  WIDTH  operand B
- req_op  in  OP_W  opcode: 001 xor, 010 sub, 011 nand, 100 add
- alu_a  out  WIDTH  registered A to ALU
- alu_b  out  WIDTH  registered B to ALU
- alu_op  out  OP_W  registered opCode to ALU; 000 when not driving
- alu_c  in  WIDTH  ALU result
- alu_carry, alu_sign, alu_zero  in  1 each  ALU flags
- rsp_valid  out  1  response held
- rsp_ready  in  1  consumer accepts
- rsp_c  out  WIDTH  captured result
- rsp_carry, rsp_sign, rsp_zero  out  1 each  captured flags
- rsp_op  out  OP_W  opcode of this response
- rsp_err  out  1  opcode was illegal
- busy  out  1  state != IDLE or FIFO non-empty

Behaviour:
- Reset (async, rst_n=0): all outputs 0; alu_op=000; FIFO emptied; state IDLE; cycle counter 0. Reset mid-operation drops the in-flight op and all queued ops with no response.
- FIFO:
  - req_ready = !full; a push occurs on req_valid & req_ready.
  - No push-through-pop when full: req_ready stays low in that cycle even if a pop occurs.
  - Pointers wrap modulo FIFO_DEPTH.
- FSM states and transitions:
  - IDLE: if FIFO non-empty, pop. Legal op: load alu_a/alu_b/alu_op, cnt=0, go DRIVE. Illegal op (000, 101-111): load rsp_* with rsp_c=0, flags=0, rsp_err=1, rsp_valid=1, go HOLD. alu_op stays 000.
  - DRIVE: alu_* held constant; cnt increments each cycle; when cnt==SERIAL_CYCLES-1, go CAPTURE. alu_op is therefore presented to ALU sampling edges for exactly SERIAL_CYCLES edges, so the ALU phase counter for that op returns to the same phase.
  - CAPTURE: alu_op driven to 000; at the next edge latch alu_c and the three flags into rsp_*, rsp_op=op, rsp_err=0, rsp_valid=1, go HOLD.
  - HOLD: rsp_* stable while rsp_valid & !rsp_ready. On handshake, clear rsp_valid and go IDLE. The next queued op begins on the following IDLE cycle; there is no IDLE bypass.
- Latency:
  - Request accepted at edge 0 into an empty, idle block: alu_op valid after edge 1, rsp_valid high after edge 7.
  - Issue throughput with rsp_ready tied high: one legal op per 8 cycles.
- Carry for xor/nand is captured as produced by the ALU (0); no recomputation in this block.
- Simultaneous push and pop on a non-full FIFO: both take effect; count is unchanged.

Decomposition:
- Shared package alu_pkg:
  - Opcode constants OP_RESET=000, OP_XOR=001, OP_SUB=010, OP_NAND=011, OP_ADD=100.
  - Function is_legal_op.
  - FSM state encoding IDLE/DRIVE/CAPTURE/HOLD.
  - SERIAL_CYCLES constant.
- One sub-module: alu_req_fifo, a synchronous FIFO of {op,a,b} with full/empty and async active-low reset.

Test Plan:
- ADD a=3,b=5, rsp_ready=1 -> alu_op=100 for 5 cycles, then 000; rsp after 7 cycles: c=8, carry=0, sign=1, zero=0, err=0.
- XOR a=5,b=5 then NAND a=F,b=F back-to-back -> responses in order: (c=0, zero=1, sign=0), then (c=0, zero=1); second alu_op=011 starts the cycle after the first HOLD handshake.
- Illegal op 111 -> alu_op never leaves 000; rsp_err=1, rsp_c=0, rsp_op=111 one cycle after pop.
- rsp_ready=0 with 3 requests issued -> first response held stable; FIFO fills to 2; req_ready=0; releasing rsp_ready drains all in order.
- rst_n pulsed low at DRIVE cnt=2 of SUB a=7,b=2 -> immediately alu_op=000, rsp_valid=0, busy=0; the next ADD a=1,b=1 yields c=2, carry=0.
- Push while popping with FIFO holding 1 entry -> count stays 1; no lost or duplicated request, checked by the rsp_op sequence.

Source files
------------

// File: rtl/alu_pkg.sv
// -----------------------------------------------------------------------------
// alu_pkg
// Shared definitions for the bit-serial ALU issue front end:
//   - opcode encodings understood by the ALU stage
//   - is_legal_op() classifier used when an op is popped from the request FIFO
//   - issue FSM state encoding
//   - default serial pass length and FIFO depth
// -----------------------------------------------------------------------------
package alu_pkg;

  localparam int ALU_WIDTH      = 4;
  localparam int ALU_OP_W       = 3;
  localparam int SERIAL_CYCLES  = 5;
  localparam int ALU_FIFO_DEPTH = 2;

  localparam logic [ALU_OP_W-1:0] OP_RESET = 3'b000;
  localparam logic [ALU_OP_W-1:0] OP_XOR   = 3'b001;
  localparam logic [ALU_OP_W-1:0] OP_SUB   = 3'b010;
  localparam logic [ALU_OP_W-1:0] OP_NAND  = 3'b011;
  localparam logic [ALU_OP_W-1:0] OP_ADD   = 3'b100;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_DRIVE   = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_HOLD    = 2'd3
  } state_t;

  // OP_RESET is not an operation the ALU can execute on request; it is the
  // idle opcode this block drives when nothing is in flight.
  function automatic logic is_legal_op(input logic [ALU_OP_W-1:0] op);
    logic legal;
    case (op)
      OP_XOR, OP_SUB, OP_NAND, OP_ADD: legal = 1'b1;
      default:                         legal = 1'b0;
    endcase
    return legal;
  endfunction

endpackage : alu_pkg

// File: rtl/alu_req_fifo.sv
// -----------------------------------------------------------------------------
// alu_req_fifo
// Small synchronous FIFO holding packed {op, a, b} requests.
//   clk, rst_n   : clock, asynchronous active-low reset (empties the FIFO)
//   push         : write push_data (ignored when full)
//   push_data    : entry to store
//   pop          : consume the head entry (ignored when empty)
//   pop_data     : head entry, valid whenever !empty
//   full, empty  : occupancy flags
// DEPTH must be a power of two so the pointers wrap naturally.
// -----------------------------------------------------------------------------
module alu_req_fifo #(
  parameter int DATA_W = 10,
  parameter int DEPTH  = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output logic [DATA_W-1:0] pop_data,
  output logic              full,
  output logic              empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic [AW:0]       count;
  logic              do_push;
  logic              do_pop;

  assign full     = (count == (AW+1)'(DEPTH));
  assign empty    = (count == '0);
  // A full FIFO refuses a push even if the same cycle pops.
  assign do_push  = push & ~full;
  assign do_pop   = pop & ~empty;
  assign pop_data = mem[rd_ptr];

  // NOTE: storage is deliberately not reset; the count gates every read, so
  // stale contents are never observed and the array can map to plain flops/RAM.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule : alu_req_fifo

// File: rtl/alu_issue_ctrl.sv
// -----------------------------------------------------------------------------
// alu_issue_ctrl
// Request/response front end for the 4-bit bit-serial ALU stage. Requests are
// queued, then each legal op is held at the ALU for exactly SERIAL_CYCLES
// edges so the ALU phase counter completes one full pass; the ALU result and
// flags are then captured into a response register.
//
// Ports:
//   clk, rst_n                      clock, asynchronous active-low reset
//   req_valid/req_ready             request handshake
//   req_a, req_b, req_op            request operands and opcode
//   alu_a, alu_b, alu_op            registered drive to the ALU (op 000 idle)
//   alu_c, alu_carry/sign/zero      ALU result and flags
//   rsp_valid/rsp_ready             response handshake
//   rsp_c, rsp_carry/sign/zero      captured result and flags
//   rsp_op, rsp_err                 opcode of the response, illegal-op flag
//   busy                            FSM not idle or requests queued
// -----------------------------------------------------------------------------
module alu_issue_ctrl #(
  parameter int WIDTH         = 4,
  parameter int OP_W          = 3,
  parameter int SERIAL_CYCLES = alu_pkg::SERIAL_CYCLES,
  parameter int FIFO_DEPTH    = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [WIDTH-1:0] req_a,
  input  logic [WIDTH-1:0] req_b,
  input  logic [OP_W-1:0]  req_op,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [OP_W-1:0]  alu_op,
  input  logic [WIDTH-1:0] alu_c,
  input  logic             alu_carry,
  input  logic             alu_sign,
  input  logic             alu_zero,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_c,
  output logic             rsp_carry,
  output logic             rsp_sign,
  output logic             rsp_zero,
  output logic [OP_W-1:0]  rsp_op,
  output logic             rsp_err,
  output logic             busy
);

  import alu_pkg::*;

  localparam int DATA_W = OP_W + 2 * WIDTH;
  localparam int CNT_W  = (SERIAL_CYCLES > 1) ? $clog2(SERIAL_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SERIAL_CYCLES - 1);

  // Request FIFO
  logic              fifo_full;
  logic              fifo_empty;
  logic              fifo_pop;
  logic [DATA_W-1:0] fifo_head;
  logic [OP_W-1:0]   head_op;
  logic [WIDTH-1:0]  head_a;
  logic [WIDTH-1:0]  head_b;

  assign req_ready = ~fifo_full;
  assign {head_op, head_a, head_b} = fifo_head;

  alu_req_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (req_valid),
    .push_data ({req_op, req_a, req_b}),
    .pop       (fifo_pop),
    .pop_data  (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  // FSM and datapath registers
  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  // Opcode of the op in flight; alu_op returns to 000 during CAPTURE, so the
  // response opcode has to come from here.
  logic [OP_W-1:0]  cur_op_q, cur_op_d;

  logic [WIDTH-1:0] alu_a_d, alu_b_d;
  logic [OP_W-1:0]  alu_op_d;
  logic             rsp_valid_d;
  logic [WIDTH-1:0] rsp_c_d;
  logic             rsp_carry_d, rsp_sign_d, rsp_zero_d;
  logic [OP_W-1:0]  rsp_op_d;
  logic             rsp_err_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      cur_op_q  <= OP_RESET;
      alu_a     <= '0;
      alu_b     <= '0;
      alu_op    <= OP_RESET;
      rsp_valid <= 1'b0;
      rsp_c     <= '0;
      rsp_carry <= 1'b0;
      rsp_sign  <= 1'b0;
      rsp_zero  <= 1'b0;
      rsp_op    <= '0;
      rsp_err   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      cur_op_q  <= cur_op_d;
      alu_a     <= alu_a_d;
      alu_b     <= alu_b_d;
      alu_op    <= alu_op_d;
      rsp_valid <= rsp_valid_d;
      rsp_c     <= rsp_c_d;
      rsp_carry <= rsp_carry_d;
      rsp_sign  <= rsp_sign_d;
      rsp_zero  <= rsp_zero_d;
      rsp_op    <= rsp_op_d;
      rsp_err   <= rsp_err_d;
    end
  end

  always_comb begin
    // NOTE: every output of this block gets a hold-value default first, so no
    // path through the case statement can leave a signal unassigned (latch).
    state_d     = state_q;
    cnt_d       = cnt_q;
    cur_op_d    = cur_op_q;
    alu_a_d     = alu_a;
    alu_b_d     = alu_b;
    alu_op_d    = alu_op;
    rsp_valid_d = rsp_valid;
    rsp_c_d     = rsp_c;
    rsp_carry_d = rsp_carry;
    rsp_sign_d  = rsp_sign;
    rsp_zero_d  = rsp_zero;
    rsp_op_d    = rsp_op;
    rsp_err_d   = rsp_err;
    fifo_pop    = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          cur_op_d = head_op;
          if (is_legal_op(head_op)) begin
            alu_a_d  = head_a;
            alu_b_d  = head_b;
            alu_op_d = head_op;
            cnt_d    = '0;
            state_d  = ST_DRIVE;
          end else begin
            // Illegal ops never reach the ALU; answer with an error response.
            rsp_c_d     = '0;
            rsp_carry_d = 1'b0;
            rsp_sign_d  = 1'b0;
            rsp_zero_d  = 1'b0;
            rsp_op_d    = head_op;
            rsp_err_d   = 1'b1;
            rsp_valid_d = 1'b1;
            state_d     = ST_HOLD;
          end
        end
      end

      ST_DRIVE: begin
        // alu_op was loaded on the IDLE->DRIVE edge and is dropped on the edge
        // leaving DRIVE, so the ALU samples it on exactly SERIAL_CYCLES edges.
        if (cnt_q == CNT_LAST) begin
          alu_op_d = OP_RESET;
          state_d  = ST_CAPTURE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      ST_CAPTURE: begin
        rsp_c_d     = alu_c;
        rsp_carry_d = alu_carry;
        rsp_sign_d  = alu_sign;
        rsp_zero_d  = alu_zero;
        rsp_op_d    = cur_op_q;
        rsp_err_d   = 1'b0;
        rsp_valid_d = 1'b1;
        state_d     = ST_HOLD;
      end

      ST_HOLD: begin
        // No IDLE bypass: the next queued op starts one cycle after handshake.
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = ST_IDLE;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  assign busy = (state_q != ST_IDLE) | ~fifo_empty;

endmodule : alu_issue_ctrl

// File: tb/tb_alu_issue_ctrl.sv
// -----------------------------------------------------------------------------
// tb_alu_issue_ctrl
// Self-checking bench for alu_issue_ctrl. A behavioural stand-in for the
// bit-serial ALU only produces its result after seeing the same opcode on
// exactly five consecutive driving edges; otherwise it shows junk. Expected
// responses are queued at request acceptance and compared on handshake.
// -----------------------------------------------------------------------------
module tb_alu_issue_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       req_valid = 1'b0;
  logic       req_ready;
  logic [3:0] req_a = '0;
  logic [3:0] req_b = '0;
  logic [2:0] req_op = '0;
  logic [3:0] alu_a, alu_b;
  logic [2:0] alu_op;
  logic [3:0] alu_c;
  logic       alu_carry, alu_sign, alu_zero;
  logic       rsp_valid;
  logic       rsp_ready = 1'b1;
  logic [3:0] rsp_c;
  logic       rsp_carry, rsp_sign, rsp_zero;
  logic [2:0] rsp_op;
  logic       rsp_err;
  logic       busy;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  alu_issue_ctrl dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_op    (req_op),
    .alu_a     (alu_a),
    .alu_b     (alu_b),
    .alu_op    (alu_op),
    .alu_c     (alu_c),
    .alu_carry (alu_carry),
    .alu_sign  (alu_sign),
    .alu_zero  (alu_zero),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_c     (rsp_c),
    .rsp_carry (rsp_carry),
    .rsp_sign  (rsp_sign),
    .rsp_zero  (rsp_zero),
    .rsp_op    (rsp_op),
    .rsp_err   (rsp_err),
    .busy      (busy)
  );

  typedef struct packed {
    logic [2:0] op;
    logic [3:0] c;
    logic       carry;
    logic       sign;
    logic       zero;
    logic       err;
  } rsp_t;

  typedef struct {
    logic [2:0] op;
    logic [3:0] a;
    logic [3:0] b;
    rsp_t       exp;
  } vec_t;

  rsp_t sb_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic rsp_t mk(input logic [2:0] op, input logic [3:0] c,
                              input logic carry, input logic sign,
                              input logic zero, input logic err);
    rsp_t r;
    r.op = op; r.c = c; r.carry = carry; r.sign = sign; r.zero = zero; r.err = err;
    return r;
  endfunction

  // ---------------------------------------------------------------- ALU model
  function automatic rsp_t alu_ref(input logic [2:0] op, input logic [3:0] a, input logic [3:0] b);
    rsp_t r;
    logic [4:0] s;
    r = '0;
    s = '0;
    case (op)
      3'b001: r.c = a ^ b;
      3'b010: begin s = {1'b0, a} + {1'b0, ~b} + 5'd1; r.c = s[3:0]; r.carry = s[4]; end
      3'b011: r.c = ~(a & b);
      3'b100: begin s = {1'b0, a} + {1'b0, b}; r.c = s[3:0]; r.carry = s[4]; end
      default: r.c = '0;
    endcase
    r.sign = r.c[3];
    r.zero = (r.c == 4'd0);
    return r;
  endfunction

  rsp_t       model_r;
  logic [2:0] phase;
  assign model_r = alu_ref(alu_op, alu_a, alu_b);

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase <= '0; alu_c <= '0; alu_carry <= 1'b0; alu_sign <= 1'b0; alu_zero <= 1'b0;
    end else if (alu_op != 3'b000) begin
      if (phase == 3'd4) begin
        phase <= '0;
        alu_c <= model_r.c; alu_carry <= model_r.carry;
        alu_sign <= model_r.sign; alu_zero <= model_r.zero;
      end else begin
        phase <= phase + 3'd1;
        alu_c <= 4'hA; alu_carry <= 1'b1; alu_sign <= 1'b1; alu_zero <= 1'b1;
      end
    end
  end

  // ----------------------------------------------------------- response monitor
  always @(negedge clk) begin
    rsp_t e;
    if (rst_n && rsp_valid && rsp_ready) begin
      if (sb_q.size() == 0) begin
        check("rsp_unexpected", 32'd1, 32'd0);
      end else begin
        e = sb_q.pop_front();
        check("rsp", {21'd0, rsp_op, rsp_c, rsp_carry, rsp_sign, rsp_zero, rsp_err}, {21'd0, e});
      end
    end
  end

  // ------------------------------------------------------------------ helpers
  task automatic sync();
    @(posedge clk);
    #1;
  endtask

  // Called just after an edge; the push lands on the next edge.
  task automatic push_now(input logic [2:0] op, input logic [3:0] a, input logic [3:0] b, input rsp_t exp);
    req_valid = 1'b1; req_op = op; req_a = a; req_b = b;
    @(negedge clk);
    check("push_ready", req_ready, 1);
    sb_q.push_back(exp);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
  endtask

  task automatic send(input logic [2:0] op, input logic [3:0] a, input logic [3:0] b, input rsp_t exp);
    bit ok;
    ok = 0;
    req_valid = 1'b1; req_op = op; req_a = a; req_b = b;
    for (int i = 0; i < 100 && !ok; i++) begin
      @(negedge clk);
      if (req_ready) ok = 1;
    end
    if (ok) sb_q.push_back(exp);
    else    check("send_timeout", 0, 1);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
  endtask

  task automatic wait_drain();
    bit done;
    done = 0;
    for (int i = 0; i < 300 && !done; i++) begin
      @(negedge clk);
      if (!busy && !rsp_valid && sb_q.size() == 0) done = 1;
    end
    check("drain", done, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // --------------------------------------------------------------------- test
  initial begin
    vec_t vecs[12];
    vecs[0]  = '{3'b100, 4'h3, 4'h5, mk(3'b100, 4'h8, 0, 1, 0, 0)};
    vecs[1]  = '{3'b010, 4'h7, 4'h2, mk(3'b010, 4'h5, 1, 0, 0, 0)};
    vecs[2]  = '{3'b010, 4'h2, 4'h7, mk(3'b010, 4'hB, 0, 1, 0, 0)};
    vecs[3]  = '{3'b100, 4'hF, 4'h1, mk(3'b100, 4'h0, 1, 0, 1, 0)};
    vecs[4]  = '{3'b001, 4'hA, 4'h5, mk(3'b001, 4'hF, 0, 1, 0, 0)};
    vecs[5]  = '{3'b011, 4'hC, 4'hA, mk(3'b011, 4'h7, 0, 0, 0, 0)};
    vecs[6]  = '{3'b000, 4'h3, 4'h4, mk(3'b000, 4'h0, 0, 0, 0, 1)};
    vecs[7]  = '{3'b101, 4'h1, 4'h1, mk(3'b101, 4'h0, 0, 0, 0, 1)};
    vecs[8]  = '{3'b110, 4'h9, 4'h9, mk(3'b110, 4'h0, 0, 0, 0, 1)};
    vecs[9]  = '{3'b100, 4'h7, 4'h7, mk(3'b100, 4'hE, 0, 1, 0, 0)};
    vecs[10] = '{3'b011, 4'h0, 4'h0, mk(3'b011, 4'hF, 0, 1, 0, 0)};
    vecs[11] = '{3'b010, 4'h5, 4'h5, mk(3'b010, 4'h0, 1, 0, 1, 0)};

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_req_ready", req_ready, 1);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_alu_op", alu_op, 0);
    check("rst_alu_a", alu_a, 0);
    check("rst_busy", busy, 0);
    check("rst_rsp_c", rsp_c, 0);
    rst_n = 1'b1;

    // Single ADD: exact issue/response timing relative to acceptance edge 0
    sync();
    push_now(3'b100, 4'h3, 4'h5, mk(3'b100, 4'h8, 0, 1, 0, 0));
    for (int k = 0; k <= 7; k++) begin
      @(negedge clk);
      check($sformatf("add_alu_op_k%0d", k), alu_op, (k >= 1 && k <= 5) ? 3'b100 : 3'b000);
      check($sformatf("add_rsp_valid_k%0d", k), rsp_valid, (k == 7) ? 1 : 0);
      if (k == 1) begin
        check("add_alu_a", alu_a, 4'h3);
        check("add_alu_b", alu_b, 4'h5);
      end
    end
    wait_drain();

    // XOR then NAND back-to-back; the NAND push coincides with the XOR pop
    sync();
    push_now(3'b001, 4'h5, 4'h5, mk(3'b001, 4'h0, 0, 0, 1, 0));
    push_now(3'b011, 4'hF, 4'hF, mk(3'b011, 4'h0, 0, 0, 1, 0));
    for (int k = 1; k <= 9; k++) begin
      @(negedge clk);
      if (k == 1) check("pushpop_req_ready", req_ready, 1);
      check($sformatf("b2b_alu_op_k%0d", k), alu_op,
            (k <= 5) ? 3'b001 : ((k == 9) ? 3'b011 : 3'b000));
      check($sformatf("b2b_rsp_valid_k%0d", k), rsp_valid, (k == 7) ? 1 : 0);
    end
    wait_drain();

    // Illegal opcode: error response one cycle after the pop, ALU untouched
    sync();
    push_now(3'b111, 4'h2, 4'h3, mk(3'b111, 4'h0, 0, 0, 0, 1));
    for (int k = 0; k <= 2; k++) begin
      @(negedge clk);
      check($sformatf("ill_alu_op_k%0d", k), alu_op, 0);
      check($sformatf("ill_rsp_valid_k%0d", k), rsp_valid, (k == 1) ? 1 : 0);
      if (k == 1) check("ill_rsp_err", rsp_err, 1);
    end
    wait_drain();

    // Vector table, back-to-back with rsp_ready high
    sync();
    for (int i = 0; i < 12; i++) begin
      send(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp);
    end
    wait_drain();

    // Backpressure: first response held, FIFO fills, then drains in order
    sync();
    rsp_ready = 1'b0;
    push_now(3'b100, 4'h1, 4'h2, mk(3'b100, 4'h3, 0, 0, 0, 0));
    push_now(3'b010, 4'h9, 4'h3, mk(3'b010, 4'h6, 1, 0, 0, 0));
    push_now(3'b001, 4'h6, 4'h3, mk(3'b001, 4'h5, 0, 0, 0, 0));
    @(negedge clk);
    check("full_req_ready", req_ready, 0);
    begin
      bit seen;
      seen = 0;
      for (int i = 0; i < 20 && !seen; i++) begin
        @(negedge clk);
        if (rsp_valid) seen = 1;
      end
      check("bp_rsp_seen", seen, 1);
    end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_hold_rsp", {rsp_valid, rsp_op, rsp_c, rsp_carry, rsp_sign, rsp_zero, rsp_err},
            {1'b1, 3'b100, 4'h3, 1'b0, 1'b0, 1'b0, 1'b0});
      check("bp_req_ready", req_ready, 0);
      check("bp_alu_op", alu_op, 0);
    end
    sync();
    rsp_ready = 1'b1;
    wait_drain();

    // Reset during DRIVE (cnt=2) of SUB 7,2: op dropped, no response
    sync();
    push_now(3'b010, 4'h7, 4'h2, mk(3'b010, 4'h5, 1, 0, 0, 0));
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("pre_rst_alu_op", alu_op, 3'b010);
    rst_n = 1'b0;
    #1;
    sb_q.delete();
    check("mid_rst_alu_op", alu_op, 0);
    check("mid_rst_rsp_valid", rsp_valid, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_req_ready", req_ready, 1);
    @(negedge clk);
    rst_n = 1'b1;
    sync();
    push_now(3'b100, 4'h1, 4'h1, mk(3'b100, 4'h2, 0, 0, 0, 0));
    wait_drain();

    check("sb_empty", sb_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_alu_issue_ctrl
